// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter in front of a 2:1 mux, feeding a
// single-entry registered output slot with a valid/ready handshake.

module multiplexor #(
  parameter int WIDTH = 5
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

module mux_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             ack0,
  output logic             ack1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state;
  logic             last;
  logic             winner;
  logic             free;
  logic             load;
  logic [WIDTH-1:0] mux_out;

  multiplexor #(.WIDTH(WIDTH)) u_mux (
    .sel (winner),
    .in0 (in0),
    .in1 (in1),
    .out (mux_out)
  );

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1)
      winner = ~last;
    else if (req1)
      winner = 1'b1;
  end

  always_comb begin
    free = (state == EMPTY) || out_ready;
    load = free && (req0 || req1);
    ack0 = load && !winner && !reset;
    ack1 = load &&  winner && !reset;
  end

  assign sel       = winner;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      out_data <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state    <= FULL;
            out_data <= mux_out;
            last     <= winner;
          end
        end
        FULL: begin
          // A load while full is a same-edge consume-and-refill.
          if (load) begin
            out_data <= mux_out;
            last     <= winner;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
